prog_loader16: RTL

- Upstream feeder of the 16-bit CPU core's programming port: drives its pg_instr, pg and rstz inputs.
- Receives a byte stream over a valid/ready handshake, parses a 16-bit word-count header and buffers the instruction words.
- Then bursts the words to the core, one per cycle, with pg high for exactly N consecutive cycles. The core writes one word per pg cycle and advances its PC by 2, so the burst must never stall.
- Finally pulses the core's reset so the PC returns to 0x8000, and releases the core to run.

---
 rtl/mas_loader_pkg.sv | 20 ++
 rtl/prog_buf16.sv | 36 +++
 rtl/prog_loader16.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mas_loader_pkg.sv
// Shared definitions for the 16-bit core program loader: FSM states and
// loader/core address constants.
package mas_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_RX_HI,
        ST_RX_LO,
        ST_BURST,
        ST_RESTART,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam int          DEPTH_DEFAULT  = 64;
    localparam logic [15:0] CPU_INSTR_BASE = 16'h8000;

endpackage

// File: rtl/prog_buf16.sv
// DEPTH x 16 instruction buffer: one write port, one registered read port.
// The read register doubles as the core's pg_instr output, so it clears when not reading.
module prog_buf16 #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-through bypass lets the last word written be fetched on the same edge.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= (wr_en && (waddr == raddr)) ? wdata : mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/prog_loader16.sv
// Byte-stream program loader for the 16-bit core: parses a word-count header,
// buffers the words, bursts them over pg/pg_instr, then restarts the core.
module prog_loader16
    import mas_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        load_req,
    output logic [15:0] pg_instr,
    output logic        pg,
    output logic        cpu_rstz,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [AW:0]   cnt;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   wptr_inc;
    logic [7:0]    hdr_hi;
    logic [7:0]    hi_byte;
    logic [15:0]   n_word;
    logic          rx_fire;
    logic          wr_en;
    logic          rd_en;
    logic          reload;

    assign rx_fire  = rx_valid & rx_ready;
    assign n_word   = {hdr_hi, rx_data};
    assign wptr_inc = wptr + 1'b1;
    assign wr_en    = (state == ST_RX_LO) && rx_fire;
    assign rd_en    = (state_nx == ST_BURST);
    assign reload   = ((state == ST_RUN) || (state == ST_ERR)) && load_req;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = ST_HDR_HI;
            ST_HDR_HI:  if (rx_fire) state_nx = ST_HDR_LO;
            ST_HDR_LO: begin
                if (rx_fire) begin
                    if (n_word == 16'd0) begin
                        state_nx = ST_RESTART;
                    end else if (n_word > DEPTH16) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_RX_HI;
                    end
                end
            end
            ST_RX_HI:   if (rx_fire) state_nx = ST_RX_LO;
            ST_RX_LO: begin
                if (rx_fire) begin
                    state_nx = (wptr_inc == cnt) ? ST_BURST : ST_RX_HI;
                end
            end
            // rptr runs one ahead of the word on pg_instr because of the prefetch.
            ST_BURST:   if (rptr == cnt) state_nx = ST_RESTART;
            ST_RESTART: state_nx = ST_RUN;
            ST_RUN:     if (load_req) state_nx = ST_HDR_HI;
            ST_ERR:     if (load_req) state_nx = ST_HDR_HI;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state    <= ST_IDLE;
            rx_ready <= 1'b0;
            pg       <= 1'b0;
            cpu_rstz <= 1'b0;
            busy     <= 1'b1;
            err      <= 1'b0;
            cnt      <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            state    <= state_nx;
            rx_ready <= state_nx inside {ST_HDR_HI, ST_HDR_LO, ST_RX_HI, ST_RX_LO};
            pg       <= (state_nx == ST_BURST);
            cpu_rstz <= (state_nx == ST_BURST) || (state_nx == ST_RUN);
            busy     <= !((state_nx == ST_RUN) || (state_nx == ST_ERR));
            err      <= (state_nx == ST_ERR);
            if ((state == ST_HDR_LO) && rx_fire) begin
                cnt <= n_word[AW:0];
            end
            if (reload) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_en) wptr <= wptr_inc;
                if (rd_en) rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_HDR_HI) && rx_fire) hdr_hi  <= rx_data;
        if ((state == ST_RX_HI)  && rx_fire) hi_byte <= rx_data;
    end

    prog_buf16 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .rstz  (rstz),
        .wr_en (wr_en),
        .waddr (wptr[AW-1:0]),
        .wdata ({hi_byte, rx_data}),
        .rd_en (rd_en),
        .raddr (rptr[AW-1:0]),
        .rdata (pg_instr)
    );

endmodule
